// File: rtl/uart_xfer_sequencer.sv
// Bus master for the MiniUART slave port: polls LSR, drains received bytes into an RX FIFO
// and writes queued TX FIFO bytes to DATA, leaving a guard gap after each write.
module uart_xfer_sequencer #(
  parameter int unsigned AW       = 4,
  parameter logic [2:0]  OFF_DATA = 3'd0,
  parameter logic [2:0]  OFF_LSR  = 3'd4,
  parameter int unsigned GUARD    = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        enable_i,
  input  logic        tx_push_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_full_o,
  output logic        tx_drop_o,
  input  logic        rx_pop_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_empty_o,
  output logic [2:0]  m_add_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned GW      = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [GW-1:0] G_ONE = GW'(1);
  localparam logic [GW-1:0] G_LD  = GW'(GUARD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POLL = 3'd1,
    ST_RXRD = 3'd2,
    ST_TXWR = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [GW-1:0]  guard_r;
  logic           ack_s;

  logic [7:0]     tx_mem_r [DEPTH];
  logic [AW:0]    tx_wr_r, tx_rd_r;
  logic           tx_empty_s, tx_full_s, tx_pop_s, tx_push_ok_s, tx_drop_r;
  logic [7:0]     tx_head_s;

  logic [7:0]     rx_mem_r [DEPTH];
  logic [AW:0]    rx_wr_r, rx_rd_r;
  logic           rx_empty_s, rx_full_s, rx_push_s, rx_push_ok_s, rx_pop_ok_s;

  logic           stb_r, we_r, stb_nxt_s, we_nxt_s;
  logic [2:0]     add_r, add_nxt_s;
  logic [31:0]    dat_r, dat_nxt_s;

  // An ack only counts while our own strobe is up (gap cycles ignore it).
  assign ack_s = m_ack_i & stb_r;

  assign tx_empty_s   = (tx_wr_r == tx_rd_r);
  assign tx_full_s    = (tx_wr_r[AW-1:0] == tx_rd_r[AW-1:0]) && (tx_wr_r[AW] != tx_rd_r[AW]);
  assign tx_pop_s     = ack_s && (state_r == ST_TXWR) && !tx_empty_s;
  assign tx_push_ok_s = tx_push_i && (!tx_full_s || tx_pop_s);
  assign tx_head_s    = tx_mem_r[tx_rd_r[AW-1:0]];

  assign rx_empty_s   = (rx_wr_r == rx_rd_r);
  assign rx_full_s    = (rx_wr_r[AW-1:0] == rx_rd_r[AW-1:0]) && (rx_wr_r[AW] != rx_rd_r[AW]);
  assign rx_pop_ok_s  = rx_pop_i && !rx_empty_s;
  assign rx_push_s    = ack_s && (state_r == ST_RXRD);
  assign rx_push_ok_s = rx_push_s && (!rx_full_s || rx_pop_ok_s);

  // TX FIFO pointers and push-overflow pulse
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_wr_r   <= '0;
      tx_rd_r   <= '0;
      tx_drop_r <= 1'b0;
    end else begin
      if (tx_push_ok_s) tx_wr_r <= tx_wr_r + PTR_ONE;
      if (tx_pop_s)     tx_rd_r <= tx_rd_r + PTR_ONE;
      tx_drop_r <= tx_push_i && !tx_push_ok_s;
    end
  end

  // TX FIFO storage
  always_ff @(posedge CLK_I) begin
    if (tx_push_ok_s) tx_mem_r[tx_wr_r[AW-1:0]] <= tx_data_i;
  end

  // RX FIFO pointers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_wr_r <= '0;
      rx_rd_r <= '0;
    end else begin
      if (rx_push_ok_s) rx_wr_r <= rx_wr_r + PTR_ONE;
      if (rx_pop_ok_s)  rx_rd_r <= rx_rd_r + PTR_ONE;
    end
  end

  // RX FIFO storage
  always_ff @(posedge CLK_I) begin
    if (rx_push_ok_s) rx_mem_r[rx_wr_r[AW-1:0]] <= m_dat_i[7:0];
  end

  assign tx_full_o  = tx_full_s;
  assign tx_drop_o  = tx_drop_r;
  assign rx_empty_o = rx_empty_s;
  assign rx_data_o  = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_r[AW-1:0]];

  // FSM state and post-write guard counter
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r <= ST_IDLE;
      guard_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (tx_pop_s)
        guard_r <= G_LD;
      else if ((state_r == ST_WAIT) && (guard_r != '0))
        guard_r <= guard_r - G_ONE;
    end
  end

  // Next-state decode; RX is served before TX so the UART never overruns
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) state_nxt_s = ST_POLL;
        else          state_nxt_s = ST_IDLE;
      end
      ST_POLL: begin
        if (!ack_s)                               state_nxt_s = ST_POLL;
        else if (!enable_i)                       state_nxt_s = ST_IDLE;
        else if (m_dat_i[0] && !rx_full_s)        state_nxt_s = ST_RXRD;
        else if (m_dat_i[5] && !tx_empty_s)       state_nxt_s = ST_TXWR;
        else                                      state_nxt_s = ST_IDLE;
      end
      ST_RXRD: begin
        if (ack_s) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_RXRD;
      end
      ST_TXWR: begin
        if (ack_s) state_nxt_s = ST_WAIT;
        else       state_nxt_s = ST_TXWR;
      end
      ST_WAIT: begin
        if (guard_r == '0) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus outputs for the coming cycle; the ack edge always drops stb for one gap cycle
  always_comb begin
    stb_nxt_s = 1'b0;
    we_nxt_s  = 1'b0;
    add_nxt_s = OFF_DATA;
    dat_nxt_s = 32'h0000_0000;
    case (state_nxt_s)
      ST_POLL: begin
        stb_nxt_s = !ack_s;
        add_nxt_s = OFF_LSR;
      end
      ST_RXRD: begin
        stb_nxt_s = !ack_s;
      end
      ST_TXWR: begin
        stb_nxt_s = !ack_s;
        we_nxt_s  = 1'b1;
        dat_nxt_s = {24'h00_0000, tx_head_s};
      end
      default: begin
        stb_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered bus outputs
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stb_r <= 1'b0;
      we_r  <= 1'b0;
      add_r <= 3'd0;
      dat_r <= 32'h0000_0000;
    end else begin
      stb_r <= stb_nxt_s;
      we_r  <= we_nxt_s;
      add_r <= add_nxt_s;
      dat_r <= dat_nxt_s;
    end
  end

  assign m_stb_o = stb_r;
  assign m_we_o  = we_r;
  assign m_add_o = add_r;
  assign m_dat_o = dat_r;

endmodule

// File: tb/tb_uart_xfer_sequencer.sv
// Directed bench for uart_xfer_sequencer with a behavioural MiniUART slave model.
module tb_uart_xfer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tx_push = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_full, tx_drop;
  logic        rx_pop = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic [2:0]  m_add;
  logic [31:0] m_dat_o, m_dat_i;
  logic        m_stb, m_we, m_ack;

  // UART model state: bench-owned knobs and model-owned counters/logs
  logic        tx_idle = 1'b0;
  int          rx_supply = 0;
  logic [7:0]  rx_base = 8'h00;
  int          ack_dly = 0;
  int          ack_cnt = 0;
  int          rx_rd_cnt = 0;
  logic [7:0]  wlog[$];
  logic [8:0]  dlog[$];
  int          hold_viol = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lsr, rd_byte;
  logic       rx_avail;

  uart_xfer_sequencer dut (
    .CLK_I(clk), .RST_I(rst), .enable_i(enable),
    .tx_push_i(tx_push), .tx_data_i(tx_data), .tx_full_o(tx_full), .tx_drop_o(tx_drop),
    .rx_pop_i(rx_pop), .rx_data_o(rx_data), .rx_empty_o(rx_empty),
    .m_add_o(m_add), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_stb_o(m_stb), .m_we_o(m_we), .m_ack_i(m_ack)
  );

  always #5 clk = ~clk;

  assign rx_avail = (rx_supply > rx_rd_cnt);
  assign lsr      = {2'b00, tx_idle, 4'b0000, rx_avail};
  assign rd_byte  = rx_base + rx_rd_cnt[7:0];
  assign m_dat_i  = (m_add == 3'd4) ? {24'h0, lsr} : {24'h0, rd_byte};
  assign m_ack    = m_stb && (ack_cnt >= ack_dly);

  // Slave side effects on each completed access
  always @(posedge clk) begin
    if (m_stb && !m_ack) ack_cnt <= ack_cnt + 1;
    else                 ack_cnt <= 0;
    if (m_stb && m_ack && m_add == 3'd0) begin
      if (m_we) begin
        wlog.push_back(m_dat_o[7:0]);
        dlog.push_back({1'b1, m_dat_o[7:0]});
      end else begin
        dlog.push_back({1'b0, rd_byte});
        rx_rd_cnt <= rx_rd_cnt + 1;
      end
    end
  end

  // Bus-rule monitor: held controls during wait states, gap after every ack
  logic       p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [2:0] p_add = 3'd0;
  logic [31:0] p_dat = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      p_stb = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (p_stb && !p_ack && !m_stb) hold_viol = hold_viol + 1;
      if (p_stb && !p_ack && m_stb && (m_add != p_add || m_we != p_we || m_dat_o != p_dat))
        hold_viol = hold_viol + 1;
      if (p_stb && p_ack && m_stb) hold_viol = hold_viol + 1;
      p_stb = m_stb; p_ack = m_ack; p_we = m_we; p_add = m_add; p_dat = m_dat_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dl(input int i);
    if (i < dlog.size()) return dlog[i];
    return 9'h1FF;
  endfunction

  function automatic logic [7:0] wl(input int i);
    if (i < wlog.size()) return wlog[i];
    return 8'hXX;
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_dat;
  } tx_vec_t;

  tx_vec_t vecs[5];

  initial begin
    int lat, gap, w0, d0, rd0;
    vecs[0] = '{8'h55, 32'h0000_0055};
    vecs[1] = '{8'h00, 32'h0000_0000};
    vecs[2] = '{8'hFF, 32'h0000_00FF};
    vecs[3] = '{8'h80, 32'h0000_0080};
    vecs[4] = '{8'h01, 32'h0000_0001};

    // ---- reset values ----
    tick(); tick();
    check("rst_stb", 32'(m_stb), 32'd0);
    check("rst_we", 32'(m_we), 32'd0);
    check("rst_add", 32'(m_add), 32'd0);
    check("rst_dat", m_dat_o, 32'd0);
    check("rst_full", 32'(tx_full), 32'd0);
    check("rst_drop", 32'(tx_drop), 32'd0);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_disabled_stb", 32'(m_stb), 32'd0);

    // ---- reset mid-POLL, with a byte queued that must be flushed ----
    ack_dly = 20;
    enable = 1'b1;
    tx_data = 8'hEE; tx_push = 1'b1; tick(); tx_push = 1'b0;
    for (int c = 0; c < 10 && !m_stb; c++) tick();
    check("poll_started", 32'(m_stb), 32'd1);
    check("poll_add", 32'(m_add), 32'd4);
    #3 rst = 1'b1;
    #1;
    check("rst_async_stb", 32'(m_stb), 32'd0);
    check("rst_async_empty", 32'(rx_empty), 32'd1);
    check("rst_async_full", 32'(tx_full), 32'd0);
    tick(); tick();
    ack_dly = 0;
    tx_idle = 1'b1;
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("flushed_no_write", 32'(wlog.size()), 32'd0);

    // ---- TX path, table driven ----
    for (int v = 0; v < 5; v++) begin
      w0 = wlog.size();
      tx_data = vecs[v].data; tx_push = 1'b1; tick(); tx_push = 1'b0;
      lat = -1;
      for (int c = 0; c < 12; c++) begin
        if (m_stb && m_we) begin lat = c; break; end
        tick();
      end
      check($sformatf("tx_lat[%0d]", v), 32'(lat >= 1 && lat <= 5), 32'd1);
      check($sformatf("tx_add[%0d]", v), 32'(m_add), 32'd0);
      check($sformatf("tx_dat[%0d]", v), m_dat_o, vecs[v].exp_dat);
      tick();
      gap = 0;
      for (int c = 0; c < 20; c++) begin
        if (m_stb) break;
        gap++;
        tick();
      end
      check($sformatf("tx_guard_gap[%0d]", v), 32'(gap >= 3), 32'd1);
      check($sformatf("tx_next_lsr[%0d]", v), 32'({m_stb, m_we, m_add}), 32'({1'b1, 1'b0, 3'd4}));
      check($sformatf("tx_nwrites[%0d]", v), 32'(wlog.size()), 32'(w0 + 1));
      check($sformatf("tx_logged[%0d]", v), 32'(wl(w0)), 32'(vecs[v].data));
    end

    // ---- RX priority over TX ----
    enable = 1'b0;
    repeat (8) tick();
    check("parked_stb", 32'(m_stb), 32'd0);
    tx_data = 8'hA5; tx_push = 1'b1; tick(); tx_push = 1'b0;
    rx_base = 8'h3C - rx_rd_cnt[7:0];
    rx_supply = rx_rd_cnt + 1;
    d0 = dlog.size();
    enable = 1'b1;
    repeat (30) tick();
    check("prio_count", 32'(dlog.size()), 32'(d0 + 2));
    check("prio_first_rd", 32'(dl(d0)), 32'({1'b0, 8'h3C}));
    check("prio_then_wr", 32'(dl(d0 + 1)), 32'({1'b1, 8'hA5}));
    check("prio_rxdata", 32'(rx_data), 32'h3C);
    check("prio_rxempty", 32'(rx_empty), 32'd0);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    check("pop_empty", 32'(rx_empty), 32'd1);
    check("pop_rxdata_zero", 32'(rx_data), 32'd0);

    // ---- TX full / drop / wrap ----
    tx_idle = 1'b0;
    repeat (4) tick();
    w0 = wlog.size();
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i); tx_push = 1'b1; tick();
      if (i == 14) check("full_after15", 32'(tx_full), 32'd0);
      if (i == 15) begin
        check("full_after16", 32'(tx_full), 32'd1);
        check("nodrop_16th", 32'(tx_drop), 32'd0);
      end
      if (i == 16) check("drop_17th", 32'(tx_drop), 32'd1);
    end
    tx_push = 1'b0; tick();
    check("drop_one_cycle", 32'(tx_drop), 32'd0);
    check("still_full", 32'(tx_full), 32'd1);
    tx_idle = 1'b1;
    for (int c = 0; c < 400 && wlog.size() < w0 + 16; c++) tick();
    repeat (20) tick();
    check("wrap_nwrites", 32'(wlog.size()), 32'(w0 + 16));
    for (int k = 0; k < 16; k++) check($sformatf("wrap_order[%0d]", k), 32'(wl(w0 + k)), 32'(k));
    check("wrap_not_full", 32'(tx_full), 32'd0);

    // ---- RX FIFO full: UART keeps its byte ----
    tx_idle = 1'b0;
    rd0 = rx_rd_cnt;
    rx_base = 8'h80;
    rx_supply = rd0 + 17;
    for (int c = 0; c < 400 && rx_rd_cnt < rd0 + 16; c++) tick();
    repeat (40) tick();
    check("rxfull_reads16", 32'(rx_rd_cnt - rd0), 32'd16);
    check("rxfull_head", 32'(rx_data), 32'(8'(8'h80 + rd0)));
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    repeat (40) tick();
    check("rxfull_one_more", 32'(rx_rd_cnt - rd0), 32'd17);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("rx_drain[%0d]", k), 32'(rx_data), 32'(8'(8'h80 + rd0 + k)));
      rx_pop = 1'b1; tick();
    end
    rx_pop = 1'b0; tick();
    check("rx_drained", 32'(rx_empty), 32'd1);

    // ---- wait-state ack ----
    ack_dly = 3;
    tx_idle = 1'b1;
    w0 = wlog.size();
    tx_data = 8'h99; tx_push = 1'b1; tick();
    tx_data = 8'h66; tick(); tx_push = 1'b0;
    for (int c = 0; c < 200 && wlog.size() < w0 + 2; c++) tick();
    repeat (60) tick();
    check("ws_nwrites", 32'(wlog.size()), 32'(w0 + 2));
    check("ws_first", 32'(wl(w0)), 32'h99);
    check("ws_second", 32'(wl(w0 + 1)), 32'h66);
    check("bus_rule_violations", 32'(hold_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
